adc_result_reader: RTL and testbench



---
 rtl/adc_reader_pkg.sv | 22 ++
 rtl/adc_result_fifo.sv | 56 +++++
 rtl/adc_result_reader.sv | 101 ++++++++++
 tb/tb_adc_result_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_reader_pkg.sv
// Shared types and widths for the ADC result reader.
// The entry carries a capture timestamp when ADC_READER_TIMESTAMP_EN is defined.
package adc_reader_pkg;

    localparam int RESULT_W = 16;
    localparam int TS_W     = 16;

    typedef struct packed {
`ifdef ADC_READER_TIMESTAMP_EN
        logic [TS_W-1:0]     timestamp;
`endif
        logic [RESULT_W-1:0] result;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Occupancy counter width: one extra bit so a full FIFO is representable.
    function automatic int fill_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/adc_result_fifo.sv
// Generic show-ahead synchronous FIFO: the head entry is presented combinationally
// from a small register file so a word pushed into an empty FIFO is visible next cycle.
module adc_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   wr_data,
    output logic [WIDTH-1:0]   rd_data,
    output logic               empty,
    output logic               full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (level == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    mem[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/adc_result_reader.sv
// Captures SAR ADC results on the rising edge of conv_finished_in into a show-ahead FIFO
// with overflow accounting. Define ADC_READER_TIMESTAMP_EN to tag each entry with a cycle count.
module adc_result_reader
    import adc_reader_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int OVF_CNT_W = 8
) (
    input  logic                       clk_dig_in,
    input  logic                       rst,
    input  logic                       enable_in,
    input  logic [RESULT_W-1:0]        result_in,
    input  logic                       conv_finished_in,
    output logic [RESULT_W-1:0]        data_out,
    output logic                       valid_out,
    input  logic                       ready_in,
`ifdef ADC_READER_TIMESTAMP_EN
    output logic [TS_W-1:0]            timestamp_out,
`endif
    output logic [fill_w(DEPTH)-1:0]   fill_level_out,
    output logic                       overflow_flag_out,
    output logic [OVF_CNT_W-1:0]       overflow_count_out,
    input  logic                       clear_in
);

    logic                 conv_q_reg;
    logic                 capture;
    logic                 pop;
    logic                 drop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 ovf_flag_reg;
    logic [OVF_CNT_W-1:0] ovf_count_reg;
    entry_t               wr_entry;
    entry_t               rd_entry;
    logic [ENTRY_W-1:0]   rd_bits;

    // conv_q resets high so a level already asserted out of reset is not a capture.
    always_ff @(posedge clk_dig_in) begin
        if (rst) conv_q_reg <= 1'b1;
        else     conv_q_reg <= conv_finished_in;
    end

    assign capture = conv_finished_in && !conv_q_reg && enable_in;
    assign pop     = !fifo_empty && ready_in;
    assign drop    = capture && fifo_full && !pop;

`ifdef ADC_READER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_reg;

    always_ff @(posedge clk_dig_in) begin
        if (rst) ts_cnt_reg <= '0;
        else     ts_cnt_reg <= ts_cnt_reg + 1'b1;
    end
`endif

    always_comb begin
        wr_entry        = '0;
        wr_entry.result = result_in;
`ifdef ADC_READER_TIMESTAMP_EN
        wr_entry.timestamp = ts_cnt_reg;
`endif
    end

    adc_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_dig_in),
        .srst    (rst),
        .push    (capture),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_bits),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fill_level_out)
    );

    assign rd_entry  = entry_t'(rd_bits);
    assign data_out  = rd_entry.result;
    assign valid_out = !fifo_empty;
`ifdef ADC_READER_TIMESTAMP_EN
    assign timestamp_out = rd_entry.timestamp;
`endif

    // Clear takes priority over a drop in the same cycle.
    always_ff @(posedge clk_dig_in) begin
        if (rst || clear_in) begin
            ovf_flag_reg  <= 1'b0;
            ovf_count_reg <= '0;
        end else if (drop) begin
            ovf_flag_reg <= 1'b1;
            if (ovf_count_reg != '1) ovf_count_reg <= ovf_count_reg + 1'b1;
        end
    end

    assign overflow_flag_out  = ovf_flag_reg;
    assign overflow_count_out = ovf_count_reg;

endmodule

// File: tb/tb_adc_result_reader.sv
// Directed self-checking bench for adc_result_reader (DEPTH=4, OVF_CNT_W=8).
module tb_adc_result_reader;

    logic        clk_dig_in = 1'b0;
    logic        rst = 1'b1;
    logic        enable_in = 1'b1;
    logic [15:0] result_in = '0;
    logic        conv_finished_in = 1'b0;
    logic [15:0] data_out;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic [2:0]  fill_level_out;
    logic        overflow_flag_out;
    logic [7:0]  overflow_count_out;
    logic        clear_in = 1'b0;
`ifdef ADC_READER_TIMESTAMP_EN
    logic [15:0] timestamp_out;
`endif

    int checks = 0;
    int failures = 0;

    adc_result_reader #(.DEPTH(4), .OVF_CNT_W(8)) dut (
        .clk_dig_in         (clk_dig_in),
        .rst                (rst),
        .enable_in          (enable_in),
        .result_in          (result_in),
        .conv_finished_in   (conv_finished_in),
        .data_out           (data_out),
        .valid_out          (valid_out),
        .ready_in           (ready_in),
`ifdef ADC_READER_TIMESTAMP_EN
        .timestamp_out      (timestamp_out),
`endif
        .fill_level_out     (fill_level_out),
        .overflow_flag_out  (overflow_flag_out),
        .overflow_count_out (overflow_count_out),
        .clear_in           (clear_in)
    );

    always #5 clk_dig_in = ~clk_dig_in;

    task automatic cycle();
        @(posedge clk_dig_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-24s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic capture(input logic [15:0] val);
        result_in = val;
        conv_finished_in = 1'b1;
        cycle();
        conv_finished_in = 1'b0;
        cycle();
    endtask

    initial begin
        logic [15:0] drain_exp [4];
        drain_exp[0] = 16'h0002;
        drain_exp[1] = 16'h0003;
        drain_exp[2] = 16'h0004;
        drain_exp[3] = 16'h0007;

        // Reset state
        cycle();
        cycle();
        chk("rst_data", data_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_fill", fill_level_out, 0);
        chk("rst_flag", overflow_flag_out, 0);
        chk("rst_count", overflow_count_out, 0);
        rst = 1'b0;
        cycle();

        // Single capture with level held 3 cycles
        result_in = 16'h2CA8;
        conv_finished_in = 1'b1;
        cycle();
        chk("single_valid", valid_out, 1);
        chk("single_data", data_out, 16'h2CA8);
        chk("single_fill", fill_level_out, 1);
        cycle();
        cycle();
        chk("single_held_fill", fill_level_out, 1);
        conv_finished_in = 1'b0;
        cycle();

        // Back-to-back drain
        capture(16'h3260);
        chk("b2b_fill2", fill_level_out, 2);
        chk("b2b_head", data_out, 16'h2CA8);
        ready_in = 1'b1;
        cycle();
        chk("b2b_second", data_out, 16'h3260);
        chk("b2b_valid2", valid_out, 1);
        cycle();
        chk("b2b_empty_valid", valid_out, 0);
        chk("b2b_empty_fill", fill_level_out, 0);
        ready_in = 1'b0;

        // Overflow: six captures into a 4-deep FIFO
        for (int i = 1; i <= 6; i++) capture(16'(i));
        chk("ovf_fill", fill_level_out, 4);
        chk("ovf_head", data_out, 16'h0001);
        chk("ovf_count", overflow_count_out, 2);
        chk("ovf_flag", overflow_flag_out, 1);
        clear_in = 1'b1;
        cycle();
        clear_in = 1'b0;
        chk("clr_flag", overflow_flag_out, 0);
        chk("clr_count", overflow_count_out, 0);
        chk("clr_fill", fill_level_out, 4);

        // Full with simultaneous pop and capture
        result_in = 16'h0007;
        conv_finished_in = 1'b1;
        ready_in = 1'b1;
        cycle();
        conv_finished_in = 1'b0;
        chk("fullpop_fill", fill_level_out, 4);
        chk("fullpop_count", overflow_count_out, 0);
        for (int i = 0; i < 4; i++) begin
            chk("fullpop_drain", data_out, drain_exp[i]);
            cycle();
        end
        chk("fullpop_empty", valid_out, 0);
        ready_in = 1'b0;

        // Clear coinciding with a drop
        for (int i = 8; i <= 11; i++) capture(16'(i));
        result_in = 16'h000C;
        conv_finished_in = 1'b1;
        clear_in = 1'b1;
        cycle();
        conv_finished_in = 1'b0;
        clear_in = 1'b0;
        chk("clrdrop_flag", overflow_flag_out, 0);
        chk("clrdrop_count", overflow_count_out, 0);
        cycle();
        capture(16'h000D);
        chk("drop_count1", overflow_count_out, 1);
        chk("drop_flag1", overflow_flag_out, 1);

        // Counter saturation
        for (int i = 0; i < 260; i++) capture(16'hEEEE);
        chk("sat_count", overflow_count_out, 8'hFF);
        chk("sat_head", data_out, 16'h0008);
        clear_in = 1'b1;
        cycle();
        clear_in = 1'b0;

        // Capture with pop at fill=1
        ready_in = 1'b1;
        cycle();
        cycle();
        cycle();
        ready_in = 1'b0;
        chk("fill1_fill", fill_level_out, 1);
        chk("fill1_head", data_out, 16'h000B);
        result_in = 16'h0055;
        conv_finished_in = 1'b1;
        ready_in = 1'b1;
        cycle();
        conv_finished_in = 1'b0;
        ready_in = 1'b0;
        chk("fill1_after_fill", fill_level_out, 1);
        chk("fill1_after_head", data_out, 16'h0055);
        cycle();
        chk("hold_data", data_out, 16'h0055);

        // Level already high when enable rises
        enable_in = 1'b0;
        result_in = 16'h00AA;
        conv_finished_in = 1'b1;
        cycle();
        cycle();
        enable_in = 1'b1;
        cycle();
        cycle();
        chk("en_rise_fill", fill_level_out, 1);
        chk("en_rise_head", data_out, 16'h0055);
        conv_finished_in = 1'b0;
        cycle();

        // Reset mid-stream, level high across reset release
        capture(16'h0066);
        capture(16'h0077);
        chk("prerst_fill", fill_level_out, 3);
        rst = 1'b1;
        conv_finished_in = 1'b1;
        cycle();
        chk("midrst_valid", valid_out, 0);
        chk("midrst_fill", fill_level_out, 0);
        rst = 1'b0;
        cycle();
        cycle();
        chk("rst_high_level_fill", fill_level_out, 0);
        conv_finished_in = 1'b0;
        cycle();

`ifdef ADC_READER_TIMESTAMP_EN
        // Timestamp: counter value before edge k after reset release is k-1
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        result_in = 16'h1111;
        conv_finished_in = 1'b1;
        cycle();
        conv_finished_in = 1'b0;
        for (int i = 0; i < 14; i++) cycle();
        result_in = 16'h2222;
        conv_finished_in = 1'b1;
        cycle();
        conv_finished_in = 1'b0;
        chk("ts_first_data", data_out, 16'h1111);
        chk("ts_first", timestamp_out, 10);
        ready_in = 1'b1;
        cycle();
        ready_in = 1'b0;
        chk("ts_second_data", data_out, 16'h2222);
        chk("ts_second", timestamp_out, 25);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
